// File: rtl/lock_pkg.sv
// lock_pkg: shared definitions for the combination-lock sequencing controller.
//   lock_state_e : controller state encoding (3-bit)
//   DISP_*       : 2-bit codes understood by the hex display decoder
//   disp_of()    : maps a controller state to its display code
package lock_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED  = 3'd0,
    ST_OPEN    = 3'd1,
    ST_SET_NEW = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_ALARM   = 3'd4
  } lock_state_e;

  localparam logic [1:0] DISP_LOCKED  = 2'b00;
  localparam logic [1:0] DISP_OPEN    = 2'b01;
  localparam logic [1:0] DISP_SET_NEW = 2'b10;
  localparam logic [1:0] DISP_ALARM   = 2'b11;

  // LOCKOUT has no code of its own; the display shows it as LOCKED.
  function automatic logic [1:0] disp_of(input lock_state_e s);
    case (s)
      ST_OPEN:    disp_of = DISP_OPEN;
      ST_SET_NEW: disp_of = DISP_SET_NEW;
      ST_ALARM:   disp_of = DISP_ALARM;
      default:    disp_of = DISP_LOCKED;
    endcase
  endfunction

endpackage

// File: rtl/sec_timer.sv
// sec_timer: one-second prescaler plus 8-bit seconds down-counter.
//   Clock, Reset : clock and synchronous active-high reset
//   load, value  : load secs_left with value and restart the prescaler
//   expire       : combinational; a tick is consuming the last second
//   secs_left    : registered remaining seconds, holds at 0
module sec_timer #(
  parameter int unsigned CLK_DIV = 50000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       load,
  input  logic [7:0] value,
  output logic       expire,
  output logic [7:0] secs_left
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc;
  logic          sec_tick;

  assign sec_tick = (presc == PRESC_MAX);
  assign expire   = sec_tick && (secs_left == 8'd1);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      presc     <= '0;
      secs_left <= 8'd0;
    end else if (load) begin
      // Loading restarts the prescaler so each timed state lasts whole seconds.
      presc     <= '0;
      secs_left <= value;
    end else begin
      presc <= sec_tick ? '0 : presc + 1'b1;
      if (sec_tick && (secs_left != 8'd0))
        secs_left <= secs_left - 8'd1;
    end
  end

endmodule

// File: rtl/lock_access_controller.sv
// lock_access_controller: policy FSM for the combination lock.
//   Clock, Reset          : clock and synchronous active-high reset
//   confirm_pulse         : enter pulse (priority over change_pulse)
//   change_pulse          : change-code pulse
//   match                 : switch code equals stored code
//   admin_clear           : clears ALARM
//   code_we               : one-cycle write strobe for the new code
//   unlock/alarm/lockout  : state flags
//   disp_code             : 2-bit display code
//   fail_cnt              : consecutive failed confirms
//   secs_left             : seconds remaining on the active timer
//
// state      | meaning
// LOCKED     | idle, waiting for confirm/change
// OPEN       | unlocked, auto-relocks on timeout
// SET_NEW    | next pulse writes the switch code, auto-relocks on timeout
// LOCKOUT    | timed penalty after a failed confirm, pulses ignored
// ALARM      | latched after MAX_TRIES failures, only admin_clear exits
module lock_access_controller
  import lock_pkg::*;
#(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned CLK_DIV        = 50000000,
  parameter int unsigned LOCKOUT_S      = 10,
  parameter int unsigned OPEN_TIMEOUT_S = 30
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       confirm_pulse,
  input  logic       change_pulse,
  input  logic       match,
  input  logic       admin_clear,
  output logic       code_we,
  output logic       unlock,
  output logic       alarm,
  output logic       lockout,
  output logic [1:0] disp_code,
  output logic [3:0] fail_cnt,
  output logic [7:0] secs_left
);

  localparam logic [3:0] MAX_T     = 4'(MAX_TRIES);
  localparam logic [7:0] LOCK_SECS = 8'(LOCKOUT_S);
  localparam logic [7:0] OPEN_SECS = 8'(OPEN_TIMEOUT_S);

  lock_state_e state, state_nxt;
  logic [3:0]  fail_nxt;
  logic        code_we_nxt;
  logic        tmr_load;
  logic [7:0]  tmr_value;
  logic        tmr_expire;

  sec_timer #(.CLK_DIV(CLK_DIV)) u_sec_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (tmr_load),
    .value    (tmr_value),
    .expire   (tmr_expire),
    .secs_left(secs_left)
  );

  // Every transition loads the timer, which also restarts the prescaler.
  always_comb begin
    state_nxt   = state;
    fail_nxt    = fail_cnt;
    code_we_nxt = 1'b0;
    tmr_load    = 1'b0;
    tmr_value   = 8'd0;
    case (state)
      ST_LOCKED: begin
        if (confirm_pulse) begin
          tmr_load = 1'b1;
          if (match) begin
            state_nxt = ST_OPEN;
            fail_nxt  = 4'd0;
            tmr_value = OPEN_SECS;
          end else if (fail_cnt + 4'd1 == MAX_T) begin
            state_nxt = ST_ALARM;
            fail_nxt  = MAX_T;
          end else begin
            state_nxt = ST_LOCKOUT;
            fail_nxt  = fail_cnt + 4'd1;
            tmr_value = LOCK_SECS;
          end
        end else if (change_pulse && match) begin
          state_nxt = ST_SET_NEW;
          tmr_load  = 1'b1;
          tmr_value = OPEN_SECS;
        end
      end
      ST_OPEN: begin
        if (confirm_pulse || (!change_pulse && tmr_expire)) begin
          state_nxt = ST_LOCKED;
          tmr_load  = 1'b1;
        end else if (change_pulse) begin
          state_nxt = ST_SET_NEW;
          tmr_load  = 1'b1;
          tmr_value = OPEN_SECS;
        end
      end
      ST_SET_NEW: begin
        if (confirm_pulse || change_pulse) begin
          state_nxt   = ST_LOCKED;
          fail_nxt    = 4'd0;
          code_we_nxt = 1'b1;
          tmr_load    = 1'b1;
        end else if (tmr_expire) begin
          state_nxt = ST_LOCKED;
          tmr_load  = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_expire) begin
          state_nxt = ST_LOCKED;
          tmr_load  = 1'b1;
        end
      end
      ST_ALARM: begin
        if (admin_clear) begin
          state_nxt = ST_LOCKED;
          fail_nxt  = 4'd0;
          tmr_load  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_LOCKED;
        tmr_load  = 1'b1;
      end
    endcase
  end

  // Flags are registered from state_nxt so they line up with the state register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= ST_LOCKED;
      fail_cnt  <= 4'd0;
      code_we   <= 1'b0;
      unlock    <= 1'b0;
      alarm     <= 1'b0;
      lockout   <= 1'b0;
      disp_code <= DISP_LOCKED;
    end else begin
      state     <= state_nxt;
      fail_cnt  <= fail_nxt;
      code_we   <= code_we_nxt;
      unlock    <= (state_nxt == ST_OPEN);
      alarm     <= (state_nxt == ST_ALARM);
      lockout   <= (state_nxt == ST_LOCKOUT);
      disp_code <= disp_of(state_nxt);
    end
  end

endmodule

// File: doc/lock_access_controller.md
Name: lock_access_controller

Overview:
Sequencing controller for the combination-lock datapath. Takes the conditioned confirm/change pulses and the datapath's code-match flag, and enforces the policy on top of them: retry counting, timed lockout, open-state auto-relock and alarm latching. It issues the new-code write strobe to the lock register and drives the 2-bit state code for the existing hex display decoder.

Parameters:
MAX_TRIES, 3, consecutive failed confirms that trigger ALARM (legal range 2..15)
CLK_DIV, 50000000, Clock cycles per one-second tick
LOCKOUT_S, 10, seconds of lockout after a non-final failed attempt (1..255)
OPEN_TIMEOUT_S, 30, seconds before OPEN or SET_NEW automatically returns to LOCKED (1..255)

Ports:
Clock  in  1  system clock; all logic on its rising edge
Reset  in  1  synchronous, active-high reset
confirm_pulse  in  1  one-cycle enter pulse from input conditioning
change_pulse  in  1  one-cycle change pulse from input conditioning
match  in  1  datapath flag: switch code equals stored code (combinational, valid every cycle)
admin_clear  in  1  one-cycle pulse that clears ALARM
code_we  out  1  one-cycle write strobe: datapath loads switch code into lock register
unlock  out  1  high while in OPEN
alarm  out  1  high while in ALARM
lockout  out  1  high while in LOCKOUT
disp_code  out  2  to hex decoder: LOCKED=00, OPEN=01, SET_NEW=10, ALARM=11, LOCKOUT=00
fail_cnt  out  4  current consecutive-failure count
secs_left  out  8  remaining seconds of the active timer; 0 when no timer is running

Behaviour:
- All outputs are registered. On Reset: state LOCKED, fail_cnt 0, secs_left 0, prescaler 0, code_we/unlock/alarm/lockout all 0, disp_code 00. Reset wins over every other input in the same cycle.
- Prescaler counts 0..CLK_DIV-1. sec_tick is asserted in the cycle the count equals CLK_DIV-1; the count then wraps to 0. Every state transition clears the prescaler to 0, so each timed state lasts a whole number of seconds.
- All transitions take effect one cycle after the triggering pulse is sampled. code_we is high for exactly that one cycle.
- Pulse priority within a cycle: confirm_pulse > change_pulse. admin_clear has effect only in ALARM.
- LOCKED:
  - confirm & match -> OPEN; fail_cnt <= 0; secs_left <= OPEN_TIMEOUT_S.
  - confirm & !match, fail_cnt+1 == MAX_TRIES -> ALARM; fail_cnt <= MAX_TRIES.
  - confirm & !match otherwise -> LOCKOUT; fail_cnt <= fail_cnt+1; secs_left <= LOCKOUT_S.
  - change & match -> SET_NEW; secs_left <= OPEN_TIMEOUT_S.
  - change & !match -> ignored; no count change.
- LOCKOUT: all pulses are ignored. On each sec_tick, secs_left decrements. When sec_tick arrives with secs_left == 1 -> LOCKED, secs_left <= 0. fail_cnt is retained.
- OPEN:
  - confirm -> LOCKED; secs_left <= 0.
  - change -> SET_NEW; secs_left reloads to OPEN_TIMEOUT_S.
  - Timer expiry (same rule as LOCKOUT) -> LOCKED.
- SET_NEW:
  - confirm or change -> code_we = 1 for one cycle, -> LOCKED, fail_cnt <= 0.
  - Timer expiry -> LOCKED with no write; stored code unchanged.
- ALARM: latched. Exits only on admin_clear -> LOCKED with fail_cnt <= 0, or on Reset. confirm/change are ignored.
- Widths: secs_left saturates at 0 and never wraps. fail_cnt never exceeds MAX_TRIES.
- Reset during LOCKOUT, ALARM or SET_NEW: no code_we is emitted; the next cycle is in LOCKED.

Decomposition:
- Shared package lock_pkg:
  - state enum (LOCKED, OPEN, SET_NEW, LOCKOUT, ALARM) as 3-bit localparams
  - disp_code encodings 00/01/10/11, shared with the hex display decoder
- One sub-module: sec_timer. It contains the prescaler plus the 8-bit down-counter, with load/value inputs and expire/secs_left outputs. Instantiated once; the FSM owns all state logic.

Test Plan:
All scenarios use CLK_DIV=4, LOCKOUT_S=2, OPEN_TIMEOUT_S=3, MAX_TRIES=3.
- Reset, then confirm with match=1 -> next cycle unlock=1, disp_code=01, secs_left=3. Idle 12 cycles -> unlock=0, disp_code=00 exactly 12 cycles after entry.
- confirm with match=0 -> lockout=1, fail_cnt=1, secs_left=2. Confirm with match=1 during lockout -> ignored. After 8 cycles -> LOCKED, fail_cnt=1.
- Three failed confirms, each after its lockout expires -> after the third, alarm=1, disp_code=11, fail_cnt=3. Confirm with match=1 -> still ALARM. admin_clear -> LOCKED, fail_cnt=0.
- change with match=1 in LOCKED -> disp_code=10. Then change -> code_we high exactly 1 cycle, then LOCKED. Repeat with no pulse for 12 cycles -> LOCKED, code_we never asserted.
- confirm and change in the same cycle with match=1 in LOCKED -> OPEN, not SET_NEW.
- Assert Reset in SET_NEW with change_pulse high in the same cycle -> code_we=0, state LOCKED, all outputs at their reset values.
